// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver:
// FSM state encodings and the frame-length helper.
package serial_pkg;

    // Frame FSM states, in the order they occur on the line.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Clock cycles from the first low cycle of the start bit to the end of stop.
    function automatic int unsigned frame_len(input int unsigned width,
                                              input int unsigned parity_en,
                                              input int unsigned clks_per_bit);
        return (1 + width + parity_en + 1) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit timer: counts CLKS_PER_BIT cycles per serial bit and flags the last one.
module serial_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT == 0) begin : g_bad_clks_per_bit
        $error("serial_baud_cnt: CLKS_PER_BIT must be at least 1");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap from LAST back to 0; clear holds the count at 0 between frames.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: accepts a parallel word with a valid/ready handshake and
// sends start bit, data LSB first, optional even parity, and a stop bit.
// Handshake: a word is taken on the rising edge where valid_i && ready_o;
// ready_o is high only in IDLE, and valid_i at any other time is dropped.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output tx_state_e        state_o
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    if (WIDTH == 0) begin : g_bad_width
        $error("serial_tx: WIDTH must be at least 1");
    end

    tx_state_e        state_q,  state_d;
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic             parity_q, parity_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic             done_q,   done_d;
    logic             tick;

    // The bit timer runs only while a frame is in progress.
    serial_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(state_q == IDLE),
        .tick_o (tick)
    );

    // Next-state logic: capture on acceptance, advance one bit per tick.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d  = START;
                    shift_d  = data_i;
                    parity_d = ^data_i;
                    idx_d    = '0;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    // Line driver: low for start, data LSB first, parity, high otherwise.
    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shift_q[0];
            PARITY:  tx_o = parity_q;
            default: tx_o = 1'b1;
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (plain 8N1 at 4 clocks/bit, with parity,
// and at 1 clock/bit). Drivers push the hand-computed line frame (bit k is the
// k-th serial bit) into a per-instance queue; monitors decode tx_o and compare.
module tb_serial_tx;
  import serial_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst_r   [3];
  logic       valid_r [3];
  logic [7:0] data_r  [3];
  logic       ready_w [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  tx_state_e  st_w    [3];
  bit         abort_r [3];
  int         done_cnt[3];

  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];

  int n_checks = 0;
  int n_pass   = 0;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_r[0]), .data_i(data_r[0]), .valid_i(valid_r[0]),
    .ready_o(ready_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .state_o(st_w[0]));

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_r[1]), .data_i(data_r[1]), .valid_i(valid_r[1]),
    .ready_o(ready_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .state_o(st_w[1]));

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst_r[2]), .data_i(data_r[2]), .valid_i(valid_r[2]),
    .ready_o(ready_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]),
    .state_o(st_w[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (done_w[i] === 1'b1) done_cnt[i]++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input int id, input logic [10:0] f);
    case (id)
      0: exp_q0.push_back(f);
      1: exp_q1.push_back(f);
      default: exp_q2.push_back(f);
    endcase
  endtask

  task automatic pop_exp(input int id, output logic [10:0] f, output bit ok);
    ok = 1'b1;
    f  = '0;
    case (id)
      0: if (exp_q0.size() > 0) f = exp_q0.pop_front(); else ok = 1'b0;
      1: if (exp_q1.size() > 0) f = exp_q1.pop_front(); else ok = 1'b0;
      default: if (exp_q2.size() > 0) f = exp_q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Decode one frame at a time from tx_o; abort when that instance is reset.
  task automatic monitor(input int id, input int nb, input int cpb);
    logic [10:0] got, exp;
    logic        v;
    bit          hold_ok, busy_ok, aborted, ok;
    int          start_cyc;
    int          last_start = -1;
    v = 1'b1;
    forever begin
      while (tx_w[id] !== 1'b0) @(negedge clk);
      start_cyc = cyc;
      got = '0; hold_ok = 1'b1; busy_ok = 1'b1; aborted = 1'b0;
      for (int b = 0; b < nb && !aborted; b++) begin
        for (int c = 0; c < cpb && !aborted; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (abort_r[id] || rst_r[id]) begin
            aborted = 1'b1;
          end else begin
            if (c == 0) begin
              v = tx_w[id];
              got[b] = v;
            end else if (tx_w[id] !== v) begin
              hold_ok = 1'b0;
            end
            if (ready_w[id] !== 1'b0 || busy_w[id] !== 1'b1) busy_ok = 1'b0;
          end
        end
      end
      if (aborted) begin
        @(negedge clk);
        continue;
      end
      @(negedge clk);
      chk($sformatf("done_at_frame_end[%0d]", id), done_w[id], 1'b1);
      pop_exp(id, exp, ok);
      chk($sformatf("frame_expected_present[%0d]", id), ok, 1'b1);
      chk($sformatf("frame_bits[%0d]", id), got, exp);
      chk($sformatf("bit_hold[%0d]", id), hold_ok, 1'b1);
      chk($sformatf("busy_not_ready[%0d]", id), busy_ok, 1'b1);
      if (id == 2 && last_start >= 0)
        chk("frame_gap", start_cyc - last_start, nb * cpb + 1);
      last_start = start_cyc;
      @(negedge clk);
      chk($sformatf("done_one_cycle[%0d]", id), done_w[id], 1'b0);
    end
  endtask

  // Offer a word, wait for acceptance, and check tx_o goes low the next cycle.
  task automatic send(input int id, input logic [7:0] d, input logic [10:0] frame,
                      input bit push, input bit hold);
    int n = 0;
    @(negedge clk);
    valid_r[id] = 1'b1;
    data_r[id]  = d;
    while (ready_w[id] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", ready_w[id], 1'b1);
      valid_r[id] = 1'b0;
      return;
    end
    if (push) push_exp(id, frame);
    @(negedge clk);
    chk($sformatf("start_latency[%0d]", id), tx_w[id], 1'b0);
    if (!hold) valid_r[id] = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n = 0;
    while (busy_w[id] !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk($sformatf("idle_timeout[%0d]", id), busy_w[id], 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_r[i] = 1'b1; valid_r[i] = 1'b0; data_r[i] = '0; abort_r[i] = 1'b0; done_cnt[i] = 0;
    end
    // Reset wins over a simultaneous valid word.
    valid_r[0] = 1'b1;
    data_r[0]  = 8'hAA;
    fork
      monitor(0, 10, 4);
      monitor(1, 11, 4);
      monitor(2, 10, 1);
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_r[i] = 1'b0;
    valid_r[0] = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx_w[0], 1'b1);
    chk("rst_ready", ready_w[0], 1'b1);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_done", done_w[0], 1'b0);
    chk("rst_state", 32'(st_w[0]), 32'(IDLE));
    chk("rst_tx_par", tx_w[1], 1'b1);
    chk("rst_ready_fast", ready_w[2], 1'b1);

    // Plain frame of 8'hA5.
    send(0, 8'hA5, 11'h34A, 1'b1, 1'b0);
    wait_idle(0);

    // 8'h3C while valid_i keeps toggling with junk data during the frame.
    send(0, 8'h3C, 11'h278, 1'b1, 1'b0);
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      valid_r[0] = k[0];
      data_r[0]  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    valid_r[0] = 1'b0;
    wait_idle(0);
    chk("no_queued_frame", busy_w[0], 1'b0);

    // Reset at frame cycle 10 aborts without a done pulse.
    send(0, 8'h55, 11'h000, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    abort_r[0] = 1'b1;
    rst_r[0]   = 1'b1;
    @(negedge clk);
    rst_r[0] = 1'b0;
    chk("abort_tx", tx_w[0], 1'b1);
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_done", done_w[0], 1'b0);
    chk("abort_state", 32'(st_w[0]), 32'(IDLE));
    repeat (3) @(negedge clk);
    chk("abort_no_done_later", done_w[0], 1'b0);
    abort_r[0] = 1'b0;

    // Next frame after the abort.
    send(0, 8'hFF, 11'h3FE, 1'b1, 1'b0);
    wait_idle(0);

    // Even parity: 8'h07 -> 1, 8'h03 -> 0.
    send(1, 8'h07, 11'h60E, 1'b1, 1'b0);
    wait_idle(1);
    send(1, 8'h03, 11'h406, 1'b1, 1'b0);
    wait_idle(1);

    // Back-to-back at one clock per bit with valid held high.
    send(2, 8'h01, 11'h202, 1'b1, 1'b1);
    send(2, 8'h80, 11'h300, 1'b1, 1'b0);
    wait_idle(2);

    repeat (5) @(negedge clk);
    chk("queue_empty0", exp_q0.size(), 0);
    chk("queue_empty1", exp_q1.size(), 0);
    chk("queue_empty2", exp_q2.size(), 0);
    chk("done_count0", done_cnt[0], 3);
    chk("done_count1", done_cnt[1], 2);
    chk("done_count2", done_cnt[2], 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
